// File: rtl/pm1_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pm1_sequencer_if
//  Description : Bundles the job request/status signals of the Pollard p-1
//                sequencer together with its two submodule master buses
//                (modular exponentiation and gcd).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH : width of n, residues, gcd operands and factor
//    KW    : width of bound, exponent and iteration count
//  Modports
//    master : sequencer view (takes job requests, drives me_*/gcd_* requests)
//    slave  : environment view (job requester plus modexp/gcd engines)
// ============================================================================
interface pm1_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int KW    = 16
);
    // Job request
    logic             start;
    logic [WIDTH-1:0] n;
    logic [KW-1:0]    bound;

    // Job status / result
    logic             busy;
    logic             done;
    logic             found;
    logic [WIDTH-1:0] factor;
    logic [KW-1:0]    iter;

    // Modular exponentiation bus
    logic             me_start;
    logic [WIDTH-1:0] me_base;
    logic [KW-1:0]    me_exp;
    logic [WIDTH-1:0] me_mod;
    logic             me_done;
    logic [WIDTH-1:0] me_result;

    // GCD bus
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;

    modport master (
        input  start, n, bound,
        output busy, done, found, factor, iter,
        output me_start, me_base, me_exp, me_mod,
        input  me_done, me_result,
        output gcd_start, gcd_a, gcd_b,
        input  gcd_done, gcd_result
    );

    modport slave (
        output start, n, bound,
        input  busy, done, found, factor, iter,
        input  me_start, me_base, me_exp, me_mod,
        output me_done, me_result,
        input  gcd_start, gcd_a, gcd_b,
        output gcd_done, gcd_result
    );
endinterface
`default_nettype wire

// File: rtl/pm1_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pm1_sequencer
//  Description : Control sequencer for Pollard's p-1 factoring stage 1.
//                Starting from a = 2 it repeatedly computes a = a^k mod n for
//                k = 2 .. bound using an external modexp engine, then asks an
//                external gcd engine for g = gcd(a-1, n). A g strictly
//                between 1 and n is a nontrivial factor.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH : width of n, residues and factor (default 32)
//    KW    : width of bound and iteration count (default 16)
//  Ports
//    clk   : single clock, rising-edge active
//    rst   : asynchronous active-high reset
//    bus   : pm1_sequencer_if.master
//            start/n/bound          job request (start is a 1-cycle pulse)
//            busy/done/found/factor/iter   status and result
//            me_start/me_base/me_exp/me_mod -> modexp request
//            me_done/me_result              <- modexp response
//            gcd_start/gcd_a/gcd_b          -> gcd request
//            gcd_done/gcd_result            <- gcd response
//  Build option
//    PM1_EARLY_GCD_EN : when defined, a gcd is taken after every
//                       exponentiation so the job can exit at the first
//                       nontrivial g; otherwise one gcd at k == bound.
// ============================================================================
module pm1_sequencer #(
    parameter int WIDTH = 32,
    parameter int KW    = 16
) (
    input  wire              clk,
    input  wire              rst,
    pm1_sequencer_if.master  bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CHECK    = 3'd1;
    localparam logic [2:0] c_EXP_REQ  = 3'd2;
    localparam logic [2:0] c_EXP_WAIT = 3'd3;
    localparam logic [2:0] c_GCD_REQ  = 3'd4;
    localparam logic [2:0] c_GCD_WAIT = 3'd5;
    localparam logic [2:0] c_EVAL     = 3'd6;
    localparam logic [2:0] c_FIN      = 3'd7;

    localparam logic [WIDTH-1:0] c_ONE_W  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_TWO_W  = WIDTH'(2);
    localparam logic [WIDTH-1:0] c_FOUR_W = WIDTH'(4);
    localparam logic [KW-1:0]    c_ONE_K  = KW'(1);
    localparam logic [KW-1:0]    c_TWO_K  = KW'(2);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_n;       // modulus latched at job start
    logic [KW-1:0]    r_bound;   // smoothness bound latched at job start
    logic [WIDTH-1:0] r_a;       // running residue a = 2^(k!) mod n
    logic [KW-1:0]    r_k;       // current exponent, also reported as iter
    logic [WIDTH-1:0] r_g;       // last gcd result
    logic             r_found;
    logic [WIDTH-1:0] r_factor;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic             w_last_k;
    logic             w_gcd_due;
    logic             w_me_active;
    logic             w_gcd_active;
    logic [WIDTH-1:0] w_a_minus_1;
    logic             w_g_nontrivial;

    assign w_last_k = (r_k == r_bound);

`ifdef PM1_EARLY_GCD_EN
    // Take a gcd after every exponentiation for the earliest possible exit.
    assign w_gcd_due = 1'b1;
`else
    // Single gcd once the full exponent 2^(bound!) has been built.
    assign w_gcd_due = w_last_k;
`endif

    // Wraps to all ones when a == 0, i.e. modulo 2^WIDTH.
    assign w_a_minus_1    = r_a - c_ONE_W;
    assign w_g_nontrivial = (r_g > c_ONE_W) && (r_g < r_n);

    assign w_me_active  = (r_state == c_EXP_REQ) || (r_state == c_EXP_WAIT);
    assign w_gcd_active = (r_state == c_GCD_REQ) || (r_state == c_GCD_WAIT);

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_n      <= '0;
            r_bound  <= '0;
            r_a      <= '0;
            r_k      <= '0;
            r_g      <= '0;
            r_found  <= 1'b0;
            r_factor <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_n      <= bus.n;
                        r_bound  <= bus.bound;
                        r_a      <= c_TWO_W;
                        r_k      <= c_TWO_K;
                        // Previous result is held only until a new job is accepted.
                        r_found  <= 1'b0;
                        r_factor <= '0;
                        r_state  <= c_CHECK;
                    end
                end

                c_CHECK: begin
                    if ((r_n < c_FOUR_W) || (r_bound < c_TWO_K)) begin
                        r_found  <= 1'b0;
                        r_factor <= '0;
                        r_state  <= c_FIN;
                    end else if (!r_n[0]) begin
                        r_found  <= 1'b1;
                        r_factor <= c_TWO_W;
                        r_state  <= c_FIN;
                    end else begin
                        r_state  <= c_EXP_REQ;
                    end
                end

                c_EXP_REQ: begin
                    r_state <= c_EXP_WAIT;
                end

                c_EXP_WAIT: begin
                    if (bus.me_done) begin
                        r_a <= bus.me_result;
                        if (w_gcd_due) begin
                            r_state <= c_GCD_REQ;
                        end else begin
                            // Not the last k here, so k < bound and cannot wrap.
                            r_k     <= r_k + c_ONE_K;
                            r_state <= c_EXP_REQ;
                        end
                    end
                end

                c_GCD_REQ: begin
                    r_state <= c_GCD_WAIT;
                end

                c_GCD_WAIT: begin
                    if (bus.gcd_done) begin
                        r_g     <= bus.gcd_result;
                        r_state <= c_EVAL;
                    end
                end

                c_EVAL: begin
                    if (w_g_nontrivial) begin
                        r_found  <= 1'b1;
                        r_factor <= r_g;
                        r_state  <= c_FIN;
                    end else if (r_g == r_n) begin
                        // Every prime factor was captured at once: no split.
                        r_found  <= 1'b0;
                        r_factor <= '0;
                        r_state  <= c_FIN;
                    end else if (w_last_k) begin
                        r_found  <= 1'b0;
                        r_factor <= '0;
                        r_state  <= c_FIN;
                    end else begin
                        r_k     <= r_k + c_ONE_K;
                        r_state <= c_EXP_REQ;
                    end
                end

                c_FIN: begin
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // Request data is gated by state so that it reads zero outside its own
    // transaction and follows the asynchronous reset without extra flops.
    // r_a only changes on the edge that leaves EXP_WAIT, so the operands stay
    // stable for the whole wait.
    // ------------------------------------------------------------------------
    assign bus.busy   = (r_state != c_IDLE);
    assign bus.done   = (r_state == c_FIN);
    assign bus.found  = r_found;
    assign bus.factor = r_factor;
    assign bus.iter   = r_k;

    assign bus.me_start = (r_state == c_EXP_REQ);
    assign bus.me_base  = w_me_active ? r_a : '0;
    assign bus.me_exp   = w_me_active ? r_k : '0;
    assign bus.me_mod   = w_me_active ? r_n : '0;

    assign bus.gcd_start = (r_state == c_GCD_REQ);
    assign bus.gcd_a     = w_gcd_active ? w_a_minus_1 : '0;
    assign bus.gcd_b     = w_gcd_active ? r_n : '0;

endmodule
`default_nettype wire

// File: tb/tb_pm1_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pm1_sequencer
//  Description : Scoreboard bench for pm1_sequencer. Behavioural modexp and
//                gcd engines answer the DUT; each issued job pushes its
//                hand-computed result into a queue that a monitor pops on
//                every done pulse. Expected values follow the build option
//                PM1_EARLY_GCD_EN when it is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pm1_sequencer;

    localparam int WIDTH      = 32;
    localparam int KW         = 16;
    localparam int ME_LAT     = 4;
    localparam int GCD_LAT    = 3;
    localparam int JOB_BUDGET = 3000;

`ifdef PM1_EARLY_GCD_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pm1_sequencer_if #(.WIDTH(WIDTH), .KW(KW)) bus ();

    pm1_sequencer #(.WIDTH(WIDTH), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic             found;
        logic [WIDTH-1:0] factor;
        logic [KW-1:0]    iter;
        int               me_cnt;
        int               gcd_cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors  = 0;
    int   checks  = 0;
    int   me_cnt  = 0;
    int   gcd_cnt = 0;
    logic [WIDTH-1:0] me_r;
    logic [WIDTH-1:0] gcd_r;

    // ------------------------------------------------------------------
    // Reference arithmetic for the behavioural engines
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] b,
                                                input logic [KW-1:0] e,
                                                input logic [WIDTH-1:0] m);
        logic [63:0] r;
        logic [63:0] x;
        r = 64'd1;
        x = {32'd0, b} % {32'd0, m};
        for (int i = 0; i < KW; i++) begin
            if (e[i]) r = (r * x) % {32'd0, m};
            x = (x * x) % {32'd0, m};
        end
        return r[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] gcd(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic exp_t mk(input logic f, input int fac, input int it,
                                input int mc, input int gc);
        exp_t e;
        e.found   = f;
        e.factor  = WIDTH'(fac);
        e.iter    = KW'(it);
        e.me_cnt  = mc;
        e.gcd_cnt = gc;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural modexp engine
    // ------------------------------------------------------------------
    initial begin
        bus.me_done   = 1'b0;
        bus.me_result = '0;
        @(negedge clk);
        forever begin
            if (bus.me_start === 1'b1) begin
                me_cnt++;
                me_r = modexp(bus.me_base, bus.me_exp, bus.me_mod);
                repeat (ME_LAT) @(negedge clk);
                bus.me_done   = 1'b1;
                bus.me_result = me_r;
                @(negedge clk);
                bus.me_done   = 1'b0;
                bus.me_result = '0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // ------------------------------------------------------------------
    // Behavioural gcd engine
    // ------------------------------------------------------------------
    initial begin
        bus.gcd_done   = 1'b0;
        bus.gcd_result = '0;
        @(negedge clk);
        forever begin
            if (bus.gcd_start === 1'b1) begin
                gcd_cnt++;
                gcd_r = gcd(bus.gcd_a, bus.gcd_b);
                repeat (GCD_LAT) @(negedge clk);
                bus.gcd_done   = 1'b1;
                bus.gcd_result = gcd_r;
                @(negedge clk);
                bus.gcd_done   = 1'b0;
                bus.gcd_result = '0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compare every completed job against the scoreboard
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no pending job");
                end else begin
                    mon_e = sb.pop_front();
                    check("found",     64'(bus.found),  64'(mon_e.found));
                    check("factor",    64'(bus.factor), 64'(mon_e.factor));
                    check("iter",      64'(bus.iter),   64'(mon_e.iter));
                    check("me_pulses", 64'(me_cnt),     64'(mon_e.me_cnt));
                    check("gcd_pulses",64'(gcd_cnt),    64'(mon_e.gcd_cnt));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic pulse_start(input int n, input int b);
        @(negedge clk);
        me_cnt    = 0;
        gcd_cnt   = 0;
        bus.start = 1'b1;
        bus.n     = WIDTH'(n);
        bus.bound = KW'(b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic issue(input int n, input int b, input exp_t e);
        sb.push_back(e);
        pulse_start(n, b);
    endtask

    // Pulse start while a job runs; the job counters must not be cleared.
    task automatic pulse_start_busy(input int n, input int b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.n     = WIDTH'(n);
        bus.bound = KW'(b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle.
    task automatic wait_done(input string name);
        int cnt;
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < JOB_BUDGET) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, cnt);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            sb.delete();
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},   64'(bus.busy),   64'd0);
        check({tag, "_done"},   64'(bus.done),   64'd0);
        check({tag, "_found"},  64'(bus.found),  64'd0);
        check({tag, "_factor"}, 64'(bus.factor), 64'd0);
        check({tag, "_iter"},   64'(bus.iter),   64'd0);
        check({tag, "_starts"}, 64'({bus.me_start, bus.gcd_start}), 64'd0);
        check({tag, "_medata"}, 64'(bus.me_base | bus.me_mod | WIDTH'(bus.me_exp)), 64'd0);
        check({tag, "_gcddata"},64'(bus.gcd_a | bus.gcd_b), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bus.start = 1'b0;
        bus.n     = '0;
        bus.bound = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);

        // 485 = 5 * 97; 2^(4!) - 1 shares the factor 5.
        issue(485, 4, mk(1'b1, 5, 4, 3, EARLY ? 3 : 1));
        wait_done("j485_b4");

        // Back to back: start lands in the cycle right after done.
        if (EARLY) issue(485, 10, mk(1'b1, 5, 4, 3, 3));
        else       issue(485, 10, mk(1'b0, 0, 10, 9, 1));
        wait_done("j485_b10");

        // Last k with g == 1: no exponentiation beyond k = 3.
        issue(485, 3, mk(1'b0, 0, 3, 2, EARLY ? 2 : 1));
        wait_done("j485_b3");

        // Even n short-circuits in CHECK.
        issue(486, 10, mk(1'b1, 2, 2, 0, 0));
        wait_done("j486");
        repeat (5) @(negedge clk);
        check("hold_found",  64'(bus.found),  64'd1);
        check("hold_factor", 64'(bus.factor), 64'd2);
        check("hold_iter",   64'(bus.iter),   64'd2);
        check("hold_busy",   64'(bus.busy),   64'd0);

        // n < 4 and bound < 2 boundaries.
        issue(3, 10, mk(1'b0, 0, 2, 0, 0));
        wait_done("j3");
        issue(485, 1, mk(1'b0, 0, 2, 0, 0));
        wait_done("j485_b1");

        // Start while busy must be ignored.
        issue(485, 4, mk(1'b1, 5, 4, 3, EARLY ? 3 : 1));
        repeat (3) @(negedge clk);
        check("busy_before_inject", 64'(bus.busy), 64'd1);
        pulse_start_busy(486, 10);
        wait_done("j485_inject");

        // Reset during EXP_WAIT; the modexp answer lands after release.
        repeat (2) @(negedge clk);
        pulse_start(485, 4);
        begin
            int cnt;
            cnt = 0;
            while (bus.me_start !== 1'b1 && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
            check("rst_job_me_start", 64'(bus.me_start), 64'd1);
        end
        @(negedge clk);
        check("expwait_base", 64'(bus.me_base), 64'd2);
        check("expwait_exp",  64'(bus.me_exp),  64'd2);
        check("expwait_mod",  64'(bus.me_mod),  64'd485);
        rst = 1'b1;
        #1;
        check_quiet("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (ME_LAT + 4) @(negedge clk);
        check_quiet("after_stale_done");

        issue(485, 4, mk(1'b1, 5, 4, 3, EARLY ? 3 : 1));
        wait_done("j485_after_rst");

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pm1_sequencer.md
PM1_SEQUENCER -- requirements
Module: pm1_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of n, residues and factor.
REQ-002 SHALL have parameter KW, default 16: width of bound and iteration count.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports start in 1 (job request pulse), n in WIDTH (number to factor) and bound in KW (smoothness bound B).
REQ-006 SHALL have outputs busy 1, done 1 (one-cycle completion pulse), found 1 (nontrivial factor found), factor WIDTH and iter KW (current/final k).
REQ-007 SHALL have modexp master ports me_start out 1, me_base out WIDTH, me_exp out KW, me_mod out WIDTH, me_done in 1 and me_result in WIDTH.
REQ-008 SHALL have gcd master ports gcd_start out 1, gcd_a out WIDTH, gcd_b out WIDTH, gcd_done in 1 and gcd_result in WIDTH.

Function
REQ-009 SHALL implement FSM states IDLE, CHECK, EXP_REQ, EXP_WAIT, GCD_REQ, GCD_WAIT, EVAL and FIN.
REQ-010 SHALL, in IDLE with start=1, latch n and bound, set a=2 and k=2, assert busy and enter CHECK; start SHALL be ignored while busy=1.
REQ-011 SHALL, in CHECK: for n<4 or bound<2, finish with found=0 and factor=0; for n even, finish with found=1 and factor=2; otherwise enter EXP_REQ.
REQ-012 SHALL, in EXP_REQ, drive me_start high for exactly one cycle with me_base=a, me_exp=k and me_mod=n, then enter EXP_WAIT.
REQ-013 SHALL, in EXP_WAIT, hold me_base, me_exp and me_mod stable; on me_done=1 it SHALL load a=me_result.
REQ-014 SHALL use a "last k" condition of k==bound.
REQ-015 SHALL, on me_done when a gcd is due (REQ-026/027), enter GCD_REQ; otherwise it SHALL increment k and enter EXP_REQ.
REQ-016 SHALL, in GCD_REQ, pulse gcd_start for one cycle with gcd_a=a-1 (mod 2^WIDTH) and gcd_b=n, then enter GCD_WAIT.
REQ-017 SHALL, in GCD_WAIT on gcd_done, register g=gcd_result and enter EVAL.
REQ-018 SHALL, in EVAL: for 1<g<n, finish with found=1 and factor=g; for g==n, finish with found=0 and factor=0.
REQ-019 SHALL, in EVAL with g==1: on the last k, finish with found=0 and factor=0; otherwise increment k and enter EXP_REQ.
REQ-020 SHALL, in FIN, pulse done for one cycle, deassert busy and return to IDLE.
REQ-021 SHALL hold found and factor from the FIN cycle until the next accepted start; iter SHALL equal k and hold after done.
REQ-022 SHALL have done-to-next-start turnaround of 0 idle cycles: start is accepted in the cycle after done.
REQ-023 SHALL keep k from wrapping, since termination occurs at k==bound ≤ 2^KW-1.
REQ-024 SHALL ignore a me_done or gcd_done received in a state other than its own WAIT state.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-job, immediately force IDLE with busy=0, done=0, found=0, factor=0, iter=0, me_start=0, gcd_start=0, and all me_*/gcd_* data outputs =0; a pending submodule result after reset SHALL be ignored.

Configuration
REQ-026 SHALL, with macro PM1_EARLY_GCD_EN defined, perform the gcd after every exponentiation (k=2..bound), allowing early exit at the first nontrivial g.
REQ-027 SHALL, without PM1_EARLY_GCD_EN, perform the gcd only once, after the exponentiation with k==bound; the EVAL g==1 path then always finishes.

Verification
REQ-028 SHALL cover: n=485, bound=4 (either config) -> done with found=1, factor=5, iter=4.
REQ-029 SHALL cover: n=485, bound=10 -> with PM1_EARLY_GCD_EN found=1, factor=5, iter=4; without it found=0, factor=0 (g==n), iter=10.
REQ-030 SHALL cover: n=485, bound=3 -> found=0, factor=0, iter=3, with no me_start pulse after k=3.
REQ-031 SHALL cover: n=486, bound=10 -> found=1, factor=2, with no me_start or gcd_start pulses; n=3 -> found=0.
REQ-032 SHALL cover: rst asserted during EXP_WAIT of the n=485 job, with me_done arriving after reset release -> IDLE and all outputs 0; a new start with n=485, bound=4 -> factor=5.
REQ-033 SHALL cover: start pulsed while busy with n=486 -> ignored; the running n=485 result is unchanged.
